// File: rtl/life_engine.sv
// life_engine: one Game of Life (B3/S23) generation per start pulse.
// Sweeps the read buffer one row per cycle and writes the next generation
// into the write buffer. Rows are held in a 3-row window: the two upper rows
// are registered, and the lower row comes straight from the registered RAM.
// Build option: define LIFE_WRAP_EN for a toroidal board. Without it, cells
// beyond the edges count as dead. Cycle timing is the same in both builds.

// One cell of the rule. up/mid/dn hold columns x-1, x, x+1; mid[1] is the cell.
module life_cell (
  input  logic [2:0] up,
  input  logic [2:0] mid,
  input  logic [2:0] dn,
  output logic       nxt
);
  logic [3:0] n;
  // Sum the eight neighbours into a 4-bit count, then apply the birth/survival rule.
  always_comb begin
    n   = 4'(up[0]) + 4'(up[1]) + 4'(up[2]) + 4'(mid[0]) + 4'(mid[2])
        + 4'(dn[0]) + 4'(dn[1]) + 4'(dn[2]);
    nxt = (n == 4'd3) || (mid[1] && (n == 4'd2));
  end
endmodule

module life_engine #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 48,
  parameter int ROW_W  = 6,
  parameter int GEN_W  = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             logic_start_in,
  output logic             logic_done_out,
  output logic             busy_out,
  output logic [ROW_W-1:0] rd_addr_out,
  input  logic [WIDTH-1:0] rd_data_in,
  output logic             wr_en_out,
  output logic [ROW_W-1:0] wr_addr_out,
  output logic [WIDTH-1:0] wr_data_out,
  output logic [GEN_W-1:0] gen_count_out
);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic [1:0]       phase_q;
  logic [ROW_W-1:0] rd_addr_q, wr_addr_q, rd_inc;
  logic [WIDTH-1:0] row_a_q, row_b_q, wr_data_q;
  logic [GEN_W-1:0] gen_q;
  logic             last_row;

  // In RUN the write address is the row being produced.
  assign last_row = (wr_addr_q == LAST_ROW);
  assign rd_inc   = (rd_addr_q == LAST_ROW) ? '0 : rd_addr_q + ROW_W'(1);

  // State register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state: 3 priming reads, HEIGHT row writes, one done cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (logic_start_in) state_d = PRIME;
      PRIME:   if (phase_q == 2'd2) state_d = RUN;
      RUN:     if (last_row) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: read-address walk, row window shift, write address/data, generation count.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      phase_q   <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      row_a_q   <= '0;
      row_b_q   <= '0;
      wr_data_q <= '0;
      gen_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (logic_start_in) begin
          rd_addr_q <= LAST_ROW;           // row above row 0 is fetched first
          phase_q   <= '0;
        end
        PRIME: begin
          phase_q   <= phase_q + 2'd1;
          rd_addr_q <= rd_inc;
          if (phase_q == 2'd2) wr_addr_q <= '0;
        end
        RUN: begin
          wr_data_q <= wr_data_out;        // keeps the data bus stable once writes stop
          if (last_row) gen_q <= gen_q + GEN_W'(1);
          else begin
            rd_addr_q <= rd_inc;
            wr_addr_q <= wr_addr_q + ROW_W'(1);
          end
        end
        default: ;
      endcase
      // Row window: row_a = row y-1, row_b = row y while row y is produced.
      if (state_q == PRIME || state_q == RUN) begin
        row_a_q <= row_b_q;
        row_b_q <= rd_data_in;
      end
    end
  end

  logic [WIDTH-1:0] up_row, dn_row, nxt_row;
`ifdef LIFE_WRAP_EN
  localparam logic WRAP = 1'b1;
  assign up_row = row_a_q;
  assign dn_row = rd_data_in;
`else
  localparam logic WRAP = 1'b0;
  // Reads still wrap in time; the wrapped rows are masked to dead cells.
  assign up_row = (wr_addr_q == '0) ? '0 : row_a_q;
  assign dn_row = last_row ? '0 : rd_data_in;
`endif

  // Column-extended rows: bit 0 is column -1, bit WIDTH+1 is column WIDTH.
  logic [WIDTH+1:0] up_x, mid_x, dn_x;
  assign up_x  = {WRAP & up_row[0],  up_row,  WRAP & up_row[WIDTH-1]};
  assign mid_x = {WRAP & row_b_q[0], row_b_q, WRAP & row_b_q[WIDTH-1]};
  assign dn_x  = {WRAP & dn_row[0],  dn_row,  WRAP & dn_row[WIDTH-1]};

  for (genvar x = 0; x < WIDTH; x++) begin : g_cell
    life_cell u_cell (
      .up  (up_x[x+2:x]),
      .mid (mid_x[x+2:x]),
      .dn  (dn_x[x+2:x]),
      .nxt (nxt_row[x])
    );
  end

  assign busy_out       = (state_q == PRIME) || (state_q == RUN);
  assign logic_done_out = (state_q == DONE);
  assign wr_en_out      = (state_q == RUN);
  assign wr_data_out    = wr_en_out ? nxt_row : wr_data_q;
  assign rd_addr_out    = rd_addr_q;
  assign wr_addr_out    = wr_addr_q;
  assign gen_count_out  = gen_q;
endmodule

// File: tb/tb_life_engine.sv
// Bench for life_engine: a reference board model predicts every written row,
// a monitor checks writes as they appear, and a driver checks cycle timing.
module tb_life_engine;
  localparam int W = 64, H = 48, RW = 6, GW = 16;
`ifdef LIFE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic          clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic          done, busy, wr_en;
  logic [RW-1:0] rd_addr, wr_addr;
  logic [W-1:0]  rd_data, wr_data;
  logic [GW-1:0] gen_cnt;

  int vectors = 0, errors = 0, exp_gen = 0;
  logic [W-1:0] board  [H];
  logic [W-1:0] nboard [H];
  logic [W-1:0] wbuf   [H];

  typedef struct packed { logic [RW-1:0] addr; logic [W-1:0] data; } wr_t;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  life_engine #(.WIDTH(W), .HEIGHT(H), .ROW_W(RW), .GEN_W(GW)) dut (
    .clk_in(clk), .rst_in(rst), .logic_start_in(start), .logic_done_out(done),
    .busy_out(busy), .rd_addr_out(rd_addr), .rd_data_in(rd_data), .wr_en_out(wr_en),
    .wr_addr_out(wr_addr), .wr_data_out(wr_data), .gen_count_out(gen_cnt)
  );

  // Registered read buffer: data one cycle after the address.
  always @(posedge clk) rd_data <= (int'(rd_addr) < H) ? board[rd_addr] : '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every write is matched against the next predicted row.
  always @(negedge clk) begin
    wr_t e;
    if (wr_en === 1'b1) begin
      if (int'(wr_addr) < H) wbuf[wr_addr] = wr_data;
      if (exp_q.size() == 0) check("unexpected_write", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        check("wr_addr", W'(wr_addr), W'(e.addr));
        check("wr_data", wr_data, e.data);
      end
    end
  end

  // Reference model: cell state with board-edge handling.
  function automatic int alive(input int r, input int c);
    if (WRAP) begin
      r = (r + H) % H;
      c = (c + W) % W;
    end else if (r < 0 || r >= H || c < 0 || c >= W) return 0;
    return board[r][c] ? 1 : 0;
  endfunction

  task automatic compute_next();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        int n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0) n += alive(r + dr, c + dc);
        nboard[r][c] = (n == 3) || (board[r][c] && n == 2);
      end
  endtask

  task automatic clear_board();
    for (int r = 0; r < H; r++) board[r] = '0;
  endtask

  task automatic advance();
    for (int r = 0; r < H; r++) board[r] = nboard[r];
  endtask

  task automatic apply_reset();
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    exp_q.delete();
    exp_gen = 0;
  endtask

  // One generation with timing checks; optional extra start pulse or reset at cycle S+k.
  task automatic run_gen(input int pulse_at, input int rst_at);
    int busy_bad = 0, first_wr = -1, wr_cnt = 0, done_at = -1, done_cnt = 0, late = 0;
    logic [RW-1:0] rd1 = '0, rd2 = '0, rd3 = '0;
    compute_next();
    for (int y = 0; y < H; y++) begin
      exp_q.push_back(wr_t'{addr: RW'(y), data: nboard[y]});
      wbuf[y] = '1;
    end
    @(negedge clk) start = 1'b1;
    @(posedge clk);                          // edge S
    for (int k = 1; k <= H + 6; k++) begin
      @(negedge clk);                        // cycle S+k
      start = (k == pulse_at);
      if (rst_at > 0 && k == rst_at + 1) begin
        check("rst_wr_en", W'(wr_en), 64'd0);
        check("rst_busy", W'(busy), 64'd0);
        check("rst_done", W'(done), 64'd0);
        check("rst_gen", W'(gen_cnt), 64'd0);
        rst = 1'b1;
        exp_q.delete();
        exp_gen = 0;
        for (int j = 0; j < 6; j++) begin
          @(negedge clk);
          if (done === 1'b1 || wr_en === 1'b1 || busy === 1'b1) late++;
        end
        check("rst_quiet", W'(late), 64'd0);
        return;
      end
      if (k == rst_at) rst = 1'b0;
      if (k == 1) rd1 = rd_addr;
      if (k == 2) rd2 = rd_addr;
      if (k == 3) rd3 = rd_addr;
      if (busy !== ((k >= 1) && (k <= H + 3))) busy_bad++;
      if (wr_en === 1'b1) begin
        if (first_wr < 0) first_wr = k;
        wr_cnt++;
      end
      if (done === 1'b1) begin
        done_at = k;
        done_cnt++;
      end
    end
    exp_gen++;
    check("prime_rd0", W'(rd1), W'(H - 1));
    check("prime_rd1", W'(rd2), 64'd0);
    check("prime_rd2", W'(rd3), 64'd1);
    check("first_write", W'(first_wr), 64'd4);
    check("write_count", W'(wr_cnt), W'(H));
    check("done_cycle", W'(done_at), W'(H + 4));
    check("done_count", W'(done_cnt), 64'd1);
    check("busy_window", W'(busy_bad), 64'd0);
    check("gen_count", W'(gen_cnt), W'(exp_gen));
    check("rows_left", W'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int bad;
    // 1: reset with start held high
    rst = 1'b0; start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_done", W'(done), 64'd0);
    check("reset_busy", W'(busy), 64'd0);
    check("reset_wr_en", W'(wr_en), 64'd0);
    check("reset_wr_addr", W'(wr_addr), 64'd0);
    check("reset_wr_data", wr_data, 64'd0);
    check("reset_rd_addr", W'(rd_addr), 64'd0);
    check("reset_gen", W'(gen_cnt), 64'd0);
    rst = 1'b1; start = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("idle_quiet", W'(bad), 64'd0);

    // 2: vertical blinker
    clear_board();
    board[10][5] = 1'b1; board[11][5] = 1'b1; board[12][5] = 1'b1;
    run_gen(0, 0);
    check("blinker_row11", wbuf[11], 64'h70);
    check("blinker_row10", wbuf[10], 64'h0);

    // 3: still life over two generations
    apply_reset();
    clear_board();
    board[20][31:30] = 2'b11; board[21][31:30] = 2'b11;
    run_gen(0, 0);
    check("block_row20", wbuf[20], 64'h3 << 30);
    advance();
    run_gen(0, 0);
    check("block_gen2", W'(gen_cnt), 64'd2);

    // 4: horizontal blinker on the bottom row across the column seam
    clear_board();
    board[47][63] = 1'b1; board[47][0] = 1'b1; board[47][1] = 1'b1;
    run_gen(0, 0);
    check("edge_row46", wbuf[46], WRAP ? 64'h1 : 64'h0);
    check("edge_row47", wbuf[47], WRAP ? 64'h1 : 64'h0);
    check("edge_row0",  wbuf[0],  WRAP ? 64'h1 : 64'h0);
    check("edge_row1",  wbuf[1],  64'h0);

    // 5: start pulse while busy is ignored
    clear_board();
    board[30][40] = 1'b1; board[30][41] = 1'b1; board[30][42] = 1'b1;
    run_gen(10, 0);

    // 6: reset mid-run, then a full generation
    apply_reset();
    run_gen(0, 20);
    run_gen(0, 0);

    // random boards, two generations each
    for (int b = 0; b < 3; b++) begin
      for (int r = 0; r < H; r++) board[r] = {$urandom, $urandom} & {$urandom, $urandom};
      run_gen(0, 0);
      advance();
      run_gen(0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
